// File: rtl/serial_fs.sv
// Bit-serial full subtractor: d = a - b - bin (mod 2^WIDTH), one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_FS_OVF_EN.
module serial_fs #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_FS_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             x, y, dbit;
`ifdef SERIAL_FS_OVF_EN
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

    assign x    = a_q[0];
    assign y    = b_q[0];
    assign dbit = x ^ y ^ br_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_FS_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                br_d    = bin;
                cnt_d   = '0;
`ifdef SERIAL_FS_OVF_EN
                amsb_d  = a[WIDTH-1];
                bmsb_d  = b[WIDTH-1];
`endif
            end
            RUN: begin
                // One extra RUN edge after the last bit publishes the result.
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                    d_d     = res_q;
                    bout_d  = br_q;
`ifdef SERIAL_FS_OVF_EN
                    ovf_d   = (amsb_q ^ bmsb_q) & (res_q[WIDTH-1] ^ amsb_q);
`endif
                end else begin
                    res_d = (res_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    br_d  = (~x & y) | (~x & br_q) | (y & br_q);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_FS_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_FS_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_FS_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
